// File: rtl/signed_arith_pkg.sv
// Shared types and constants for the signed add/subtract accumulator.
package signed_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic OP_ADD      = 1'b0;
  localparam logic OP_SUB      = 1'b1;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_ACC    = 1'b1;

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronises an asynchronous button level and flags its rising edge.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic go_pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level    = sync[SYNC_STAGES-1];
  assign go_pulse = level & ~prev;

endmodule

// File: rtl/signed_addsub_acc.sv
// Button-triggered signed add/subtract with overflow flag, sign/magnitude
// output for the display and an optional accumulate mode.
module signed_addsub_acc
  import signed_arith_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             OP,
  input  logic             MODE,
  input  logic             GO,
  input  logic             CLR,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] MAG,
  output logic             SIGN,
  output logic             VALID,
  output logic             DONE,
  output logic             BUSY
);

  localparam int MSB = WIDTH - 1;

  state_t           state, state_nxt;
  logic             go_level, go_pulse;
  logic [WIDTH-1:0] x_q, y_q, acc_q;
  logic             op_q, mode_q;
  logic [WIDTH-1:0] r, mag_c;
  logic             ovf;

  btn_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_go_sync (
    .clk     (CLK),
    .rst     (RST),
    .din     (GO),
    .level   (go_level),
    .go_pulse(go_pulse)
  );

  // Subtraction is done directly rather than via negating Y, so the most
  // negative Y needs no special case.
  always_comb begin
    r     = '0;
    ovf   = 1'b0;
    mag_c = '0;
    if (op_q == OP_SUB) begin
      r   = x_q - y_q;
      ovf = (x_q[MSB] != y_q[MSB]) && (r[MSB] != x_q[MSB]);
    end else begin
      r   = x_q + y_q;
      ovf = (x_q[MSB] == y_q[MSB]) && (r[MSB] != x_q[MSB]);
    end
    mag_c = r[MSB] ? -r : r;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!CLR && go_pulse) state_nxt = CALC;
      CALC:    state_nxt = HOLD;
      HOLD:    if (!go_level) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_q    <= '0;
      y_q    <= '0;
      op_q   <= OP_ADD;
      mode_q <= MODE_DIRECT;
      acc_q  <= '0;
      RESULT <= '0;
      MAG    <= '0;
      SIGN   <= 1'b0;
      VALID  <= 1'b1;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == IDLE) begin
        if (CLR) begin
          acc_q  <= '0;
          RESULT <= '0;
          MAG    <= '0;
          SIGN   <= 1'b0;
          VALID  <= 1'b1;
        end else if (go_pulse) begin
          x_q    <= (MODE == MODE_ACC) ? acc_q : A;
          y_q    <= B;
          op_q   <= OP;
          mode_q <= MODE;
        end
      end else if (state == CALC) begin
        RESULT <= r;
        SIGN   <= r[MSB];
        VALID  <= ~ovf;
        MAG    <= mag_c;
        DONE   <= 1'b1;
        // An overflowed result never pollutes the running total.
        if (mode_q == MODE_ACC && !ovf) acc_q <= r;
      end
    end
  end

  assign BUSY = (state == CALC) || (state == HOLD);

endmodule

// File: tb/tb_signed_addsub_acc.sv
// Self-checking bench: vector table plus hand sequences, scoreboard on DONE.
module tb_signed_addsub_acc;

  localparam int W  = 5;
  localparam int SS = 2;

  logic         CLK = 1'b0;
  logic         RST, OP, MODE, GO, CLR;
  logic [W-1:0] A, B;
  logic [W-1:0] RESULT, MAG;
  logic         SIGN, VALID, DONE, BUSY;

  always #5 CLK = ~CLK;

  signed_addsub_acc #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .OP(OP), .MODE(MODE), .GO(GO),
    .CLR(CLR), .RESULT(RESULT), .MAG(MAG), .SIGN(SIGN), .VALID(VALID),
    .DONE(DONE), .BUSY(BUSY)
  );

  typedef struct {
    logic [W-1:0] result;
    logic [W-1:0] mag;
    logic         sign;
    logic         valid;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (DONE === 1'b1) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: DONE=1 with no operation outstanding");
      end else begin
        e = sb.pop_front();
        chk("result", RESULT, e.result);
        chk("mag", MAG, e.mag);
        chk("sign", SIGN, e.sign);
        chk("valid", VALID, e.valid);
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    exp_t        e;
    int          sa, sb_, rs;
    logic [31:0] s;
    sa      = int'($signed(a));
    sb_     = int'($signed(b));
    s       = op ? sa - sb_ : sa + sb_;
    e.valid = ($signed(s) >= -16) && ($signed(s) <= 15);
    e.result = s[W-1:0];
    rs      = int'($signed(e.result));
    e.mag   = W'(rs < 0 ? -rs : rs);
    e.sign  = rs < 0;
    return e;
  endfunction

  task automatic check_outputs(input string tag, input logic [W-1:0] r, input logic [W-1:0] m,
                               input logic s, input logic v);
    chk({tag, "_result"}, RESULT, r);
    chk({tag, "_mag"}, MAG, m);
    chk({tag, "_sign"}, SIGN, s);
    chk({tag, "_valid"}, VALID, v);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("busy_release", BUSY, 0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic press(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                       input logic mode, input exp_t e);
    int n, d0;
    A = a; B = b; OP = op; MODE = mode;
    sb.push_back(e);
    d0 = dones;
    @(posedge CLK);
    #1 GO = 1'b1;
    n = 0;
    while (dones == d0 && n < 20) begin
      @(negedge CLK);
      #1 n++;
    end
    chk("done_seen", dones - d0, 1);
    chk("latency_in_range", (n >= SS + 2 && n <= SS + 3) ? 1 : 0, 1);
    chk("busy_during", BUSY, 1);
    A = ~a; B = ~b; OP = ~op; MODE = ~mode;
    @(negedge CLK);
    GO = 1'b0;
    wait_idle();
    chk("single_done", dones - d0, 1);
    chk("hold_result", RESULT, e.result);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   d0, n;
    exp_t e;

    vecs[0] = '{5'd7,  5'd5,  1'b0, '{5'd12, 5'd12, 1'b0, 1'b1}};
    vecs[1] = '{5'd7,  5'd9,  1'b0, '{5'd16, 5'd16, 1'b1, 1'b0}};
    vecs[2] = '{5'd24, 5'd8,  1'b1, '{5'd16, 5'd16, 1'b1, 1'b1}};
    vecs[3] = '{5'd3,  5'd16, 1'b1, '{5'd19, 5'd13, 1'b1, 1'b0}};
    vecs[4] = '{5'd16, 5'd31, 1'b0, '{5'd15, 5'd15, 1'b0, 1'b0}};
    vecs[5] = '{5'd15, 5'd16, 1'b1, '{5'd31, 5'd1,  1'b1, 1'b0}};
    vecs[6] = '{5'd27, 5'd26, 1'b0, '{5'd21, 5'd11, 1'b1, 1'b1}};
    vecs[7] = '{5'd0,  5'd16, 1'b0, '{5'd16, 5'd16, 1'b1, 1'b1}};
    vecs[8] = '{5'd16, 5'd16, 1'b1, '{5'd0,  5'd0,  1'b0, 1'b1}};

    RST = 1'b1; GO = 1'b0; CLR = 1'b0; A = '0; B = '0; OP = 1'b0; MODE = 1'b0;
    repeat (3) @(negedge CLK);
    check_outputs("reset", 5'd0, 5'd0, 1'b0, 1'b1);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_outputs("post_reset", 5'd0, 5'd0, 1'b0, 1'b1);

    foreach (vecs[i]) press(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, vecs[i].e);

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      logic         rop;
      ra  = W'($urandom_range(0, 31));
      rb  = W'($urandom_range(0, 31));
      rop = 1'($urandom_range(0, 1));
      press(ra, rb, rop, 1'b0, model(ra, rb, rop));
    end

    // CLR coincident with a GO edge after an overflowed result
    press(5'd7, 5'd9, 1'b0, 1'b0, '{5'd16, 5'd16, 1'b1, 1'b0});
    d0 = dones;
    @(posedge CLK);
    #1 CLR = 1'b1; GO = 1'b1;
    repeat (8) @(negedge CLK);
    CLR = 1'b0;
    repeat (3) @(negedge CLK);
    check_outputs("clr_go", 5'd0, 5'd0, 1'b0, 1'b1);
    GO = 1'b0;
    repeat (3) @(negedge CLK);
    chk("clr_go_no_done", dones - d0, 0);

    // Accumulate: a rejected overflow must leave ACC at 10
    @(negedge CLK); CLR = 1'b1;
    @(negedge CLK); CLR = 1'b0;
    press(5'd3, 5'd10, 1'b0, 1'b1, '{5'd10, 5'd10, 1'b0, 1'b1});
    press(5'd3, 5'd10, 1'b0, 1'b1, '{5'd20, 5'd12, 1'b1, 1'b0});
    press(5'd3, 5'd10, 1'b0, 1'b1, '{5'd20, 5'd12, 1'b1, 1'b0});
    press(5'd3, 5'd10, 1'b1, 1'b1, '{5'd0,  5'd0,  1'b0, 1'b1});

    // GO held for 50 cycles yields one operation
    A = 5'd1; B = 5'd2; OP = 1'b0; MODE = 1'b0;
    sb.push_back('{5'd3, 5'd3, 1'b0, 1'b1});
    d0 = dones;
    @(posedge CLK);
    #1 GO = 1'b1;
    repeat (50) @(negedge CLK);
    chk("hold50_busy", BUSY, 1);
    chk("hold50_one_done", dones - d0, 1);
    GO = 1'b0;
    wait_idle();

    // RST during CALC aborts without DONE
    A = 5'd9; B = 5'd4; OP = 1'b0; MODE = 1'b0;
    d0 = dones;
    @(posedge CLK);
    #1 GO = 1'b1;
    n = 0;
    while (!BUSY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("reached_calc", BUSY, 1);
    #1 RST = 1'b1;
    @(negedge CLK);
    check_outputs("rst_calc", 5'd0, 5'd0, 1'b0, 1'b1);
    GO = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rst_calc_no_done", dones - d0, 0);
    press(5'd5, 5'd29, 1'b0, 1'b0, '{5'd2, 5'd2, 1'b0, 1'b1});

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
